reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port general-purpose register file for the next-generation CPU core. It supports a configurable data width and depth, NUM_RD read ports and two write ports with fixed write priority. Register 0 is hardwired to zero. A post-reset clear sequencer zeroes every register, one per cycle, and reports completion on init_done. The block sits between decode (reads) and writeback (writes), like the current single-write register file.

Parameters:
DATA_WIDTH, 32, width of each register in bits
ADDR_WIDTH, 5, address width; depth DEPTH = 2**ADDR_WIDTH
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
init_done  output  1  1 = clear sequence finished, file usable
wen0  input  1  write enable, port 0
waddr0  input  ADDR_WIDTH  write address, port 0
wdata0  input  DATA_WIDTH  write data, port 0
wen1  input  1  write enable, port 1 (higher priority)
waddr1  input  ADDR_WIDTH  write address, port 1
wdata1  input  DATA_WIDTH  write data, port 1
raddr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  output  NUM_RD*DATA_WIDTH  packed read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. There is no asynchronous reset anywhere.
- FSM has two states, CLEAR and READY.
  - rst=1 at an edge: state <= CLEAR, clear pointer ptr <= 1, init_done <= 0.
  - This holds regardless of current state; reset mid-clear restarts from ptr=1.
- CLEAR, each edge with rst=0:
  - reg[ptr] <= 0.
  - If ptr == DEPTH-1: state <= READY and init_done <= 1 at the same edge.
  - Otherwise ptr <= ptr+1.
- CLEAR timing: DEPTH-1 clearing edges in total. For ADDR_WIDTH=5, init_done is 1 after the 31st rst-low edge.
- Register contents are not reset directly by rst; only the sequencer zeroes them.
- While CLEAR: wen0 and wen1 are ignored (no write takes effect), and all rdata ports return 0.
- READY: init_done stays 1 until the next rst.
- Writes (READY only), on posedge:
  - wen0 && waddr0!=0: reg[waddr0] <= wdata0.
  - wen1 && waddr1!=0: reg[waddr1] <= wdata1.
  - Both enabled with waddr0==waddr1!=0: wdata1 is stored; port 0 is dropped.
  - Writes to address 0 are discarded on either port.
- Reads are combinational, zero latency. rdata[i] = 0 if raddr[i]==0 or state==CLEAR; otherwise reg[raddr[i]] (pre-edge value, unless bypass enabled).
- Read ports are fully independent. Any number of ports may read the same address.
- Address width equals full depth, so no out-of-range addresses exist.

Optional Feature:
Macro: REG_FILE_MP_BYPASS_EN
- Defined: in READY, a read whose address matches an enabled, non-zero same-cycle write address returns that write data combinationally. Port 1 data wins if both write ports match. Address 0 still reads 0. Bypass is inactive in CLEAR.
- Undefined: reads return the stored value only; same-cycle write data becomes visible the cycle after the edge.

Test Plan:
- Clear timing: rst high 2 cycles, then low -> init_done=0 for edges 1..30 and 1 after edge 31. During clear, wen0=1 waddr0=5 wdata0=0xDEAD -> later read of r5 = 0.
- Reset mid-clear: after 10 clear cycles, pulse rst 1 cycle -> init_done rises exactly 31 edges after rst falls again. Earlier contents of r1..r31 read 0.
- Write conflict: READY, wen0=wen1=1, waddr0=waddr1=7, wdata0=0x11111111, wdata1=0x22222222 -> next cycle rdata[0] for raddr=7 = 0x22222222.
- Dual independent writes plus r0: waddr0=3/0xA5A5A5A5 and waddr1=0/0xFFFFFFFF -> r3 = 0xA5A5A5A5, raddr=0 reads 0 on all ports.
- Multi-read: NUM_RD=4, all raddr=3 -> all four rdata = 0xA5A5A5A5. Distinct addrs 1..4 after writing 1..4 -> each port returns its own value.
- Bypass: wen1=1 waddr1=9 wdata1=0x1234, raddr[0]=9 same cycle -> rdata[0]=0x1234 with macro defined, old value (0) without it.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port general-purpose register file.
//   NUM_RD combinational read ports and two write ports. Port 1 has priority
//   when both ports write the same address. Register 0 always reads as zero.
//   After reset a clear sequencer zeroes registers 1..DEPTH-1, one per cycle.
//   It then raises init_done. While clearing, writes are ignored and all
//   reads return zero.
//
// Ports:
//   clk              system clock, all state changes on posedge
//   rst              synchronous active-high reset (restarts the clear sequence)
//   init_done        1 = clear finished, the file is usable
//   wen0/waddr0/wdata0   write port 0
//   wen1/waddr1/wdata1   write port 1 (wins on an address conflict)
//   raddr            packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata            packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//
// Build option:
//   REG_FILE_MP_BYPASS_EN  when defined and the file is ready, a read returns
//                          the data of a same-cycle write to the same non-zero
//                          address. Port 1 data has priority over port 0.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         init_done,
    input  logic                         wen0,
    input  logic [ADDR_WIDTH-1:0]        waddr0,
    input  logic [DATA_WIDTH-1:0]        wdata0,
    input  logic                         wen1,
    input  logic [ADDR_WIDTH-1:0]        waddr1,
    input  logic [DATA_WIDTH-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    done_q, done_d;

    // Entry 0 is never written and never read; reads of address 0 are forced to zero.
    logic [DATA_WIDTH-1:0]   regs [DEPTH];
    logic [ADDR_WIDTH-1:0]   ra;

    // ---------------------------------------------------------------
    // Clear sequencer
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= ADDR_WIDTH'(1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = done_q;
        case (state_q)
            CLEAR: begin
                // The last address is all ones, so the file turns ready at the same
                // edge that clears the last register.
                if (ptr_q == '1) begin
                    state_d = READY;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
            end
            READY: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign init_done = done_q;

    // ---------------------------------------------------------------
    // Storage: clearing in CLEAR, writes in READY
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs[ptr_q] <= '0;
            end else begin
                if (wen0 && (waddr0 != '0)) begin
                    regs[waddr0] <= wdata0;
                end
                // Port 1 is assigned last, so it wins when both ports write the same address.
                if (wen1 && (waddr1 != '0)) begin
                    regs[waddr1] <= wdata1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Combinational read ports
    // ---------------------------------------------------------------
    always_comb begin
        rdata = '0;
        ra    = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if ((state_q == READY) && (ra != '0)) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
`ifdef REG_FILE_MP_BYPASS_EN
                if (wen0 && (waddr0 == ra)) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata0;
                end
                if (wen1 && (waddr1 == ra)) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata1;
                end
`else
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp with four read ports.
// The stimulus process drives one cycle of inputs. It computes the expected
// outputs from a reference model (an array plus a count of clear edges) and
// pushes them to a queue. The monitor pops one entry at each falling edge and
// compares it with the DUT outputs.
module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 2 ** AW;

    logic              clk;
    logic              rst;
    logic              init_done;
    logic              wen0, wen1;
    logic [AW-1:0]     waddr0, waddr1;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .wen0      (wen0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .wen1      (wen1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .raddr     (raddr),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             done;
        logic [NR*DW-1:0] rd;
    } exp_t;

    exp_t        sb_q [$];
    int          checks = 0;
    int          errors = 0;

    // Reference model
    logic [DW-1:0] mem [DEPTH];
    int            clear_edges;   // rst-low edges seen since the last reset
    logic          known;         // the model state is defined once a reset edge has occurred

    function automatic logic m_ready();
        return (clear_edges >= DEPTH - 1);
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a,
                                               input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                               input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        if (!m_ready() || a == 0) return '0;
`ifdef REG_FILE_MP_BYPASS_EN
        if (w1 && a1 == a) return d1;
        if (w0 && a0 == a) return d0;
`endif
        return mem[a];
    endfunction

    function automatic logic [NR*AW-1:0] pack4(input int p0, input int p1, input int p2, input int p3);
        logic [NR*AW-1:0] r;
        r = {AW'(p3), AW'(p2), AW'(p1), AW'(p0)};
        return r;
    endfunction

    function automatic logic [NR*AW-1:0] rand_raddr();
        logic [NR*AW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*AW +: AW] = AW'($urandom_range(DEPTH - 1, 0));
        return r;
    endfunction

    task automatic cycle(input logic r,
                         input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [NR*AW-1:0] ra);
        exp_t e;
        rst = r; wen0 = w0; waddr0 = a0; wdata0 = d0;
        wen1 = w1; waddr1 = a1; wdata1 = d1; raddr = ra;
        if (known) begin
            e.done = m_ready();
            for (int i = 0; i < NR; i++)
                e.rd[i*DW +: DW] = exp_read(ra[i*AW +: AW], w0, a0, d0, w1, a1, d1);
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            clear_edges = 0;
            known = 1'b1;
        end else if (!m_ready()) begin
            clear_edges++;
            mem[clear_edges] = '0;
        end else begin
            if (w0 && a0 != 0) mem[a0] = d0;
            if (w1 && a1 != 0) mem[a1] = d1;
        end
        #1;
    endtask

    task automatic idle_read(input logic [NR*AW-1:0] ra);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ra);
    endtask

    task automatic rand_cycle(input int rst_odds);
        logic [AW-1:0] a0, a1;
        a0 = AW'($urandom_range(DEPTH - 1, 0));
        a1 = ($urandom_range(3, 0) == 0) ? a0 : AW'($urandom_range(DEPTH - 1, 0));
        cycle(($urandom_range(rst_odds - 1, 0) == 0),
              1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom, rand_raddr());
    endtask

    // Monitor: compares one scoreboard entry at each falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (init_done !== e.done) begin
                    errors++;
                    $display("FAIL init_done t=%0t got %b want %b", $time, init_done, e.done);
                end
                for (int i = 0; i < NR; i++) begin
                    checks++;
                    if (rdata[i*DW +: DW] !== e.rd[i*DW +: DW]) begin
                        errors++;
                        $display("FAIL rdata[%0d] t=%0t raddr=%0d got %h want %h", i, $time,
                                 raddr[i*AW +: AW], rdata[i*DW +: DW], e.rd[i*DW +: DW]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        known = 1'b0;
        clear_edges = 0;
        rst = 1'b1; wen0 = 1'b0; wen1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; raddr = '0;
        @(posedge clk);
        clear_edges = 0;
        known = 1'b1;
        #1;

        // Second reset cycle, then a full clear with port 0 trying to write r5
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        for (int k = 0; k < DEPTH - 1; k++)
            cycle(1'b0, 1'b1, AW'(5), 32'hDEAD, 1'($urandom), AW'($urandom), $urandom, rand_raddr());
        idle_read(pack4(5, 5, 0, 31));

        // Write conflict on r7, port 1 wins
        cycle(1'b0, 1'b1, AW'(7), 32'h1111_1111, 1'b1, AW'(7), 32'h2222_2222, pack4(7, 0, 0, 0));
        idle_read(pack4(7, 7, 1, 2));

        // Independent writes: r3 on port 0, address 0 on port 1 (discarded)
        cycle(1'b0, 1'b1, AW'(3), 32'hA5A5_A5A5, 1'b1, AW'(0), 32'hFFFF_FFFF, pack4(3, 0, 0, 0));
        idle_read(pack4(0, 0, 0, 0));
        idle_read(pack4(3, 3, 3, 3));

        // Distinct values in r1..r4, read back on separate ports
        cycle(1'b0, 1'b1, AW'(1), 32'h0000_0001, 1'b1, AW'(2), 32'h0000_0002, pack4(1, 2, 3, 4));
        cycle(1'b0, 1'b1, AW'(3), 32'h0000_0003, 1'b1, AW'(4), 32'h0000_0004, pack4(1, 2, 3, 4));
        idle_read(pack4(1, 2, 3, 4));

        // Same-cycle write and read of r9 (bypass-dependent result)
        cycle(1'b0, 1'b0, AW'(9), 32'h5555, 1'b1, AW'(9), 32'h1234, pack4(9, 9, 0, 1));
        idle_read(pack4(9, 0, 0, 0));
        cycle(1'b0, 1'b1, AW'(9), 32'hBEEF, 1'b1, AW'(10), 32'hCAFE, pack4(9, 10, 9, 10));

        // Random traffic with occasional resets
        for (int k = 0; k < 300; k++) rand_cycle(64);

        // Fill the file, reset, reset again mid-clear, then confirm everything reads 0
        for (int k = 0; k < DEPTH; k++)
            cycle(1'b0, 1'b1, AW'(k), $urandom | 32'h1, 1'b0, '0, '0, rand_raddr());
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        for (int k = 0; k < 10; k++) rand_cycle(1000000);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        for (int k = 0; k < DEPTH - 1; k++)
            cycle(1'b0, 1'b1, AW'(k), $urandom, 1'b1, AW'(k + 1), $urandom, rand_raddr());
        for (int k = 0; k < DEPTH / NR; k++)
            idle_read(pack4(4 * k, 4 * k + 1, 4 * k + 2, 4 * k + 3));

        for (int k = 0; k < 200; k++) rand_cycle(128);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
